// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, bubble word,
// cpu opcode constants and small address helpers.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        S_ADDR    = 2'd0,
        S_REQ     = 2'd1,
        S_DELIVER = 2'd2
    } fetch_state_e;

    // AND r0,r0,r0 encodes as all zeros
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_ADDI = 4'b1100;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_LUI  = 4'b1101;

    function automatic logic addr_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_timeout_ctr.sv
// Saturating wait-cycle counter for the memory request; expired marks the last
// permitted cycle of an outstanding request.
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_r;

    assign expired = (count_r == LAST);

    // cycle counter, held at LAST until cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {CW{1'b0}};
        end else if (clr) begin
            count_r <= {CW{1'b0}};
        end else if (en && !expired) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: samples pc, runs a req/ack memory read and hands the
// word to the cpu for one cycle, replacing misaligned or timed-out fetches by a bubble.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = NOP_WORD,
    parameter int                TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic              stall,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_ack,
    output logic              err,
    output logic [31:0]       fetch_count
);

    fetch_state_e      state_r, state_nx_s;
    logic [ADDR_W-1:0] fetch_addr_r, fetch_addr_nx_s;
    logic [DATA_W-1:0] instr_r, instr_nx_s;
    logic              err_r, err_nx_s;
    logic              req_r, valid_r, stall_r;
    logic [31:0]       fetch_count_r;
    logic              tmo_en_s, tmo_clr_s, tmo_expired_s;

    fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr_s),
        .en      (tmo_en_s),
        .expired (tmo_expired_s)
    );

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_ADDR;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // next state and next datapath values
    always_comb begin
        state_nx_s      = state_r;
        fetch_addr_nx_s = fetch_addr_r;
        instr_nx_s      = instr_r;
        err_nx_s        = err_r;
        tmo_en_s        = 1'b0;
        tmo_clr_s       = 1'b1;
        case (state_r)
            S_ADDR: begin
                fetch_addr_nx_s = pc;
                if (addr_misaligned(pc[1:0])) begin
                    instr_nx_s  = NOP_INSTR;
                    err_nx_s    = 1'b1;
                    state_nx_s  = S_DELIVER;
                end else begin
                    state_nx_s  = S_REQ;
                end
            end
            S_REQ: begin
                tmo_en_s  = 1'b1;
                tmo_clr_s = 1'b0;
                // a same-cycle ack beats the timeout and leaves err untouched
                if (imem_ack) begin
                    instr_nx_s = imem_rdata;
                    tmo_clr_s  = 1'b1;
                    state_nx_s = S_DELIVER;
                end else if (tmo_expired_s) begin
                    instr_nx_s = NOP_INSTR;
                    err_nx_s   = 1'b1;
                    tmo_clr_s  = 1'b1;
                    state_nx_s = S_DELIVER;
                end else begin
                    state_nx_s = S_REQ;
                end
            end
            S_DELIVER: begin
                state_nx_s = S_ADDR;
            end
            default: begin
                state_nx_s = S_ADDR;
            end
        endcase
    end

    // registered outputs, decoded from the upcoming state so they align with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_addr_r  <= {ADDR_W{1'b0}};
            instr_r       <= NOP_INSTR;
            err_r         <= 1'b0;
            req_r         <= 1'b0;
            valid_r       <= 1'b0;
            stall_r       <= 1'b1;
            fetch_count_r <= 32'd0;
        end else begin
            fetch_addr_r  <= fetch_addr_nx_s;
            instr_r       <= instr_nx_s;
            err_r         <= err_nx_s;
            req_r         <= (state_nx_s == S_REQ);
            valid_r       <= (state_nx_s == S_DELIVER);
            stall_r       <= (state_nx_s != S_DELIVER);
            if (state_r == S_DELIVER) begin
                fetch_count_r <= fetch_count_r + 32'd1;
            end else begin
                fetch_count_r <= fetch_count_r;
            end
        end
    end

    assign instruction = instr_r;
    assign instr_valid = valid_r;
    assign stall       = stall_r;
    assign imem_addr   = fetch_addr_r;
    assign imem_req    = req_r;
    assign err         = err_r;
    assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: bench-driven memory responder, scoreboard of
// expected instruction words, immediate-assertion checks.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        stall;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        err;
    logic [31:0] fetch_count;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_instr;
    logic        err_m;
    logic [31:0] fc_m;

    localparam logic [31:0] NOP = 32'h0000_0000;

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .stall       (stall),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .err         (err),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_instr = NOP;
        err_m      = 1'b0;
        fc_m       = 32'd0;
    endtask

    // Called in an ADDR cycle; returns in the DELIVER cycle. ack_cycle 0 = never ack.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d,
                            input int ack_cycle, input int exp_req);
        int          n_req;
        bit          done;
        logic [31:0] e;
        pc = a;
        if (a[1:0] != 2'b00 || ack_cycle == 0) begin
            exp_q.push_back(NOP);
            err_m = 1'b1;
        end else begin
            exp_q.push_back(d);
        end
        check("addr_req_low", {31'd0, imem_req}, 32'd0);
        n_req = 0;
        done  = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            if (instr_valid) begin
                e = exp_q.pop_front();
                check("instruction", instruction, e);
                check("deliver_stall", {31'd0, stall}, 32'd0);
                check("deliver_req", {31'd0, imem_req}, 32'd0);
                check("req_cycles", n_req, exp_req);
                check("err", {31'd0, err}, {31'd0, err_m});
                last_instr = e;
                fc_m       = fc_m + 32'd1;
                imem_ack   = 1'b0;
                done       = 1'b1;
            end else begin
                check("wait_stall", {31'd0, stall}, 32'd1);
                check("instr_hold", instruction, last_instr);
                if (imem_req) begin
                    n_req++;
                    check("imem_addr", imem_addr, a);
                    imem_ack   = (n_req == ack_cycle);
                    imem_rdata = (n_req == ack_cycle) ? d : 32'hBAAD_F00D;
                end else begin
                    imem_ack = 1'b0;
                end
            end
        end
        if (!done) check("fetch_done", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b0; pc = 32'd0; imem_ack = 1'b0; imem_rdata = 32'd0;
        model_reset();
        repeat (2) tick();
        check("rst_instruction", instruction, NOP);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd1);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        rst = 1'b1;

        // zero-wait fetch, delayed fetch, misaligned, aligned after error
        do_fetch(32'h0, 32'hC123_0001, 1, 1);
        tick(); check("count", fetch_count, fc_m);
        do_fetch(32'h4, 32'h4321_0000, 4, 4);
        tick(); check("count", fetch_count, fc_m);
        do_fetch(32'h6, 32'h7777_7777, 1, 0);
        tick(); check("count", fetch_count, fc_m);
        do_fetch(32'h10, 32'h5555_AAAA, 2, 2);
        tick(); check("count", fetch_count, fc_m);

        // timeout, then stray ack across DELIVER and ADDR
        do_fetch(32'h20, 32'h9999_9999, 0, 15);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        check("stray_instr", instruction, NOP);
        check("count", fetch_count, fc_m);
        do_fetch(32'hC, 32'h1111_2222, 3, 3);
        tick(); check("count", fetch_count, fc_m);

        // reset during the second REQ cycle
        pc = 32'h14;
        tick(); check("req1", {31'd0, imem_req}, 32'd1);
        tick(); check("req2", {31'd0, imem_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_async_req", {31'd0, imem_req}, 32'd0);
        check("rst_async_instr", instruction, NOP);
        check("rst_async_count", fetch_count, 32'd0);
        check("rst_async_err", {31'd0, err}, 32'd0);
        model_reset();
        pc = 32'h8; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0BAD;
        #2 rst = 1'b1;
        do_fetch(32'h8, 32'h8888_0008, 1, 1);
        tick(); check("count", fetch_count, fc_m);

        // fresh reset, then sequential fetch and branch redirect
        rst = 1'b0;
        #2;
        model_reset();
        rst = 1'b1;
        do_fetch(32'h0, 32'hA000_0000, 1, 1);
        tick();
        do_fetch(32'h4, 32'hA000_0004, 2, 2);
        tick();
        do_fetch(32'h8, 32'h8123_0010, 1, 1);
        tick();
        do_fetch(32'h40, 32'hA000_0040, 1, 1);
        tick();
        check("redirect_count", fetch_count, 32'd4);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage sitting directly upstream of the cpu core.
- Each fetch cycle it latches the core's pc and runs a request/acknowledge read on instruction memory.
- It then presents the returned word on the core's instruction input for exactly one cycle, qualified by instr_valid; stall is asserted at all other times.
- Detects misaligned pc and memory timeout, substitutes a bubble instruction and flags a sticky error.

Parameters:
- ADDR_W, 32, width of pc and imem_addr.
- DATA_W, 32, instruction width.
- NOP_INSTR, 32'h0000_0000, bubble word delivered on reset/error (AND r0,r0,r0).
- TIMEOUT, 15, max cycles in REQ without imem_ack before abandoning the fetch.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- pc  in  ADDR_W  byte address of next instruction, from cpu.
- instruction  out  DATA_W  instruction word to cpu.
- instr_valid  out  1  instruction is valid; cpu executes/advances pc on this cycle's edge.
- stall  out  1  equals !instr_valid; cpu must hold pc and state.
- imem_addr  out  ADDR_W  memory read address.
- imem_req  out  1  read request, held until ack or timeout.
- imem_rdata  in  DATA_W  read data, valid when imem_ack=1.
- imem_ack  in  1  read completion, single-cycle pulse.
- err  out  1  sticky: misaligned pc or timeout seen since reset.
- fetch_count  out  32  number of instr_valid pulses since reset, wraps at 2^32.

Behaviour:
- Reset (rst=0, async):
  - state=ADDR; instruction=NOP_INSTR; instr_valid=0; stall=1.
  - imem_req=0 immediately, without waiting for a clock; imem_addr=0.
  - err=0; fetch_count=0; timeout counter=0.
- FSM states ADDR, REQ, DELIVER, all transitions on the rising edge.
- ADDR (1 cycle):
  - fetch_addr<=pc; imem_req=0.
  - If pc[1:0]!=0: instruction<=NOP_INSTR, err<=1, next DELIVER; no memory access.
  - Else next REQ.
- REQ:
  - imem_req=1; imem_addr=fetch_addr, stable for the whole state; timeout counter increments each cycle.
  - imem_ack=1: instruction<=imem_rdata, counter<=0, next DELIVER. An ack in the first REQ cycle is legal.
  - Counter reaches TIMEOUT-1 with no ack: instruction<=NOP_INSTR, err<=1, counter<=0, next DELIVER, imem_req drops.
  - Ack and timeout in the same cycle: ack wins, and err is not set.
- DELIVER (1 cycle): instr_valid=1, stall=0, fetch_count<=fetch_count+1, next ADDR.
- Throughput and latency:
  - Minimum 3 cycles per instruction (ADDR, REQ with same-cycle ack, DELIVER).
  - In DELIVER the cpu samples instruction; its new pc is stable by the following ADDR cycle.
- instruction holds its last value outside DELIVER and changes only at a REQ ack, a timeout, or a misaligned ADDR.
- imem_ack outside REQ (late or stray) is ignored: no capture, no state change.
- Branch/redirect needs no special handling because pc is resampled in every ADDR cycle.
- Reset mid-REQ: imem_req drops asynchronously. After release, fetch restarts at ADDR from the current pc, and an ack arriving after release while in ADDR is ignored.
- err stays at 1 until reset; fetching continues normally after an error.

Decomposition:
- Shared package holds:
  - FSM state encoding (ADDR=2'd0, REQ=2'd1, DELIVER=2'd2);
  - the NOP_INSTR constant;
  - opcode constants already used by the cpu (ADD=4'b0100, ADDI=4'b1100, BEQ=4'b1000, LUI=4'b1101).
- One natural sub-module, fetch_timeout_ctr: a saturating cycle counter with clear and expired flag, parameterized by TIMEOUT.

Test Plan:
- Reset, then zero-wait memory returning 32'hC123_0001 for pc=0 -> imem_req high in cycle 2, instr_valid pulse in cycle 3 with instruction=C1230001, fetch_count=1, err=0.
- Memory ack delayed 4 cycles, pc=4 returning 32'h4321_0000 -> imem_addr=4 and imem_req stable for 4 cycles, stall=1 throughout, single instr_valid pulse with 43210000.
- pc=32'h6 -> no imem_req asserted, instruction=00000000 with instr_valid=1, err=1 and stays 1 for later aligned fetches.
- Memory never acks, TIMEOUT=15 -> imem_req high exactly 15 cycles, then instr_valid with NOP_INSTR, err=1; a stray ack 2 cycles later changes nothing.
- rst asserted in 2nd REQ cycle -> imem_req=0 before the next clock edge, instruction=0, fetch_count=0; after release, a fetch of pc=8 completes normally.
- Sequence pc=0,4,8 then redirect to 0x40 (beq taken) -> imem_addr values 0,4,8,0x40 in order, fetch_count=4.
